// File: rtl/alu_reg.sv
// alu_reg: signed ALU with registered result, zero and error flags, one operation per clock
module alu_reg #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [3:0]         op,
  input  logic               invalid_data,
  output logic [2*WIDTH-1:0] out,
  output logic               zero,
  output logic               error
);
  logic signed [2*WIDTH-1:0] a, b, b_div, res, out_d, out_q;
  logic div0, bad_op, error_d, error_q, zero_d, zero_q;
  always_comb begin
    a      = {{WIDTH{in1[WIDTH-1]}}, in1};
    b      = {{WIDTH{in2[WIDTH-1]}}, in2};
    div0   = (op == 4'd3) && (in2 == '0);
    b_div  = div0 ? 2*WIDTH'(1) : b;
    bad_op = op[3];
    res    = '0;
    case (op)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a * b;
      4'd3:    res = a / b_div;
      4'd4:    res = a & b;
      4'd5:    res = a | b;
      4'd6:    res = a ^ b;
      4'd7:    res = ~a;
      default: res = '0;
    endcase
    error_d = invalid_data | div0 | bad_op;
    out_d   = error_d ? '0 : res;
    zero_d  = !error_d && (res == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      zero_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      zero_q  <= zero_d;
      error_q <= error_d;
    end
  end
  assign out   = out_q;
  assign zero  = zero_q;
  assign error = error_q;
endmodule

// File: tb/tb_alu_reg.sv
// tb_alu_reg: directed and random checks of alu_reg at WIDTH=8
module tb_alu_reg;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] in1, in2;
  logic [3:0] op;
  logic invalid_data;
  logic [15:0] out;
  logic zero, error;
  int n_cmp = 0;
  int n_bad = 0;
  alu_reg #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .op(op),
    .invalid_data(invalid_data), .out(out), .zero(zero), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input int a, input int b, input int o, input int inv);
    in1 = 8'(a);
    in2 = 8'(b);
    op = 4'(o);
    invalid_data = inv[0];
  endtask
  task automatic run(input string tag, input int a, input int b, input int o, input int inv,
                     input int e_out, input int e_zero, input int e_err);
    drive(a, b, o, inv);
    @(posedge clk);
    #1;
    chk({tag, ".out"}, 32'($signed(out)), e_out);
    chk({tag, ".zero"}, {31'd0, zero}, e_zero);
    chk({tag, ".error"}, {31'd0, error}, e_err);
  endtask
  initial begin
    int a, b, o, e_out, e_err;
    rst = 1'b1;
    drive(100, 27, 2, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("rst.out", 32'($signed(out)), 0);
      chk("rst.zero", {31'd0, zero}, 0);
      chk("rst.error", {31'd0, error}, 0);
    end
    drive(3, 4, 0, 0);
    #2;
    rst = 1'b0;
    run("first", 3, 4, 0, 0, 7, 0, 0);
    run("add_ovf", 127, 1, 0, 0, 128, 0, 0);
    run("add_zero", -5, 5, 0, 0, 0, 1, 0);
    run("sub_neg", -128, 1, 1, 0, -129, 0, 0);
    run("mul_max", -128, -128, 2, 0, 16384, 0, 0);
    run("mul_neg", -3, 7, 2, 0, -21, 0, 0);
    run("div_trunc", -7, 2, 3, 0, -3, 0, 0);
    run("div_ovf", -128, -1, 3, 0, 128, 0, 0);
    run("div_zero", 5, 0, 3, 0, 0, 0, 1);
    run("and", -16, 60, 4, 0, 48, 0, 0);
    run("or", 3, -128, 5, 0, -125, 0, 0);
    run("xor", 85, -1, 6, 0, -86, 0, 0);
    run("not", 0, 99, 7, 0, -1, 0, 0);
    run("invalid", 10, 3, 0, 1, 0, 0, 1);
    run("inv_div0", 10, 0, 3, 1, 0, 0, 1);
    run("bad_op", 10, 3, 12, 0, 0, 0, 1);
    run("bad_op15", 0, 0, 15, 0, 0, 0, 1);
    rst = 1'b1;
    run("rst_prio", 10, 3, 12, 1, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      a = $signed(8'($urandom));
      b = $signed(8'($urandom));
      o = int'($urandom_range(0, 3));
      e_err = 0;
      case (o)
        0: e_out = a + b;
        1: e_out = a - b;
        2: e_out = a * b;
        default: begin
          e_err = (b == 0) ? 1 : 0;
          e_out = (b == 0) ? 0 : a / b;
        end
      endcase
      run($sformatf("rand%0d", i), a, b, o, 0, e_out, (e_err == 0 && e_out == 0) ? 1 : 0, e_err);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
